// File: rtl/sound_ctrl_pkg.sv
// sound_ctrl_pkg: shared constants and types for the sound trigger controller.
// Build option (used by sound_trigger_slot): SOUND_PER_CHANNEL_CMP_EN.
package sound_ctrl_pkg;

   localparam int unsigned DEF_COORD_W = 10;
   localparam int unsigned DEF_COLOR_W = 10;
   // Two guard bits so the sum of three channels cannot overflow.
   localparam int unsigned SUM_GUARD_W = 2;
   // Width of slot indices and of the reported sound number.
   localparam int unsigned IDX_W       = 4;

   // Width of an R+G+B sum for a given channel width.
   function automatic int unsigned sum_width(input int unsigned color_w);
      return color_w + SUM_GUARD_W;
   endfunction

   // One trigger slot as seen from outside, at the default widths.
   typedef struct packed {
      logic [DEF_COORD_W-1:0] x;
      logic [DEF_COORD_W-1:0] y;
      logic [DEF_COLOR_W-1:0] r;
      logic [DEF_COLOR_W-1:0] g;
      logic [DEF_COLOR_W-1:0] b;
      logic                   valid;
   } slot_t;

   typedef enum logic {
      MODE_RECORD = 1'b0,
      MODE_PLAY   = 1'b1
   } mode_e;

endpackage

// File: rtl/sound_trigger_slot.sv
// sound_trigger_slot: one trigger point. Holds the captured coordinate and
// reference colour, matches the live pixel position, compares colours, keeps
// the per-frame hit flag and the saturating debounce counter.
// Build option: SOUND_PER_CHANNEL_CMP_EN selects per-channel colour distance
// instead of the summed R+G+B distance.
module sound_trigger_slot
   import sound_ctrl_pkg::*;
#(
   parameter int COORD_W    = 10,
   parameter int COLOR_W    = 10,
   parameter int TOL        = 48,
   parameter int HIT_FRAMES = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               we,
   input  logic               pix_valid,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COLOR_W-1:0] r,
   input  logic [COLOR_W-1:0] g,
   input  logic [COLOR_W-1:0] b,
   output logic               active
);

   localparam int               CNT_W   = $clog2(HIT_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIT_FRAMES);

   logic [COORD_W-1:0] x_r;
   logic [COORD_W-1:0] y_r;
   logic [COLOR_W-1:0] r_r;
   logic [COLOR_W-1:0] g_r;
   logic [COLOR_W-1:0] b_r;
   logic               valid_r;
   logic               flag_r;
   logic [CNT_W-1:0]   cnt_r;

   logic               col_hit;
   logic               pix_hit;

`ifdef SOUND_PER_CHANNEL_CMP_EN
   localparam logic [COLOR_W-1:0] TOL_C = COLOR_W'(TOL);

   function automatic logic [COLOR_W-1:0] chan_dist(input logic [COLOR_W-1:0] a,
                                                    input logic [COLOR_W-1:0] c);
      return (a > c) ? (a - c) : (c - a);
   endfunction

   // Hit when any single channel strays further than the threshold.
   always_comb begin
      col_hit = (chan_dist(r, r_r) > TOL_C) ||
                (chan_dist(g, g_r) > TOL_C) ||
                (chan_dist(b, b_r) > TOL_C);
   end
`else
   localparam int               SUM_W = int'(sum_width(COLOR_W));
   localparam logic [SUM_W-1:0] TOL_S = SUM_W'(TOL);

   logic [SUM_W-1:0] pix_sum;
   logic [SUM_W-1:0] ref_sum;
   logic [SUM_W-1:0] sum_dist;

   // Hit when the brightness sum differs from the reference by more than TOL.
   always_comb begin
      pix_sum  = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
      ref_sum  = SUM_W'(r_r) + SUM_W'(g_r) + SUM_W'(b_r);
      sum_dist = (pix_sum > ref_sum) ? (pix_sum - ref_sum) : (ref_sum - pix_sum);
      col_hit  = (sum_dist > TOL_S);
   end
`endif

   // Qualify the colour hit with position, slot validity and play mode.
   always_comb begin
      pix_hit = !clr && pix_valid && valid_r && (x == x_r) && (y == y_r) && col_hit;
   end

   // Slot storage, written by the capture decode in the top level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_r     <= '0;
         y_r     <= '0;
         r_r     <= '0;
         g_r     <= '0;
         b_r     <= '0;
         valid_r <= 1'b0;
      end else if (we) begin
         x_r     <= x;
         y_r     <= y;
         r_r     <= r;
         g_r     <= g;
         b_r     <= b;
         valid_r <= 1'b1;
      end
   end

   // Frame flag and debounce counter; a pixel hit in the frame-start cycle
   // belongs to the new frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_r <= 1'b0;
         cnt_r  <= '0;
      end else if (clr) begin
         flag_r <= 1'b0;
         cnt_r  <= '0;
      end else if (frame_start) begin
         if (valid_r && flag_r) begin
            cnt_r <= (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_W'(1));
         end else begin
            cnt_r <= '0;
         end
         flag_r <= pix_hit;
      end else begin
         flag_r <= flag_r | pix_hit;
      end
   end

   assign active = valid_r && (cnt_r == CNT_MAX);

endmodule

// File: rtl/sound_trigger_ctrl.sv
// sound_trigger_ctrl: NUM_PTS colour trigger points on the VGA pixel stream.
// Record mode captures reference pixels into slots; play mode debounces
// per-frame colour hits and reports the lowest active slot as a sound number.
// Build option: SOUND_PER_CHANNEL_CMP_EN (per-channel colour compare).
module sound_trigger_ctrl
   import sound_ctrl_pkg::*;
#(
   parameter int NUM_PTS    = 4,
   parameter int COORD_W    = 10,
   parameter int COLOR_W    = 10,
   parameter int TOL        = 48,
   parameter int HIT_FRAMES = 3
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               i_pix_valid,
   input  logic               i_frame_start,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic [COLOR_W-1:0] i_vga_r,
   input  logic [COLOR_W-1:0] i_vga_g,
   input  logic [COLOR_W-1:0] i_vga_b,
   input  logic               i_mode,
   input  logic               i_save,
   input  logic [3:0]         i_save_idx,
   output logic               o_save_done,
   output logic [NUM_PTS-1:0] o_hit_mask,
   output logic [3:0]         o_sound_num,
   output logic               o_sound_valid
);

   localparam logic [IDX_W-1:0] NUM_PTS_I = IDX_W'(NUM_PTS);

   mode_e              mode_r;
   logic               armed_r;
   logic [IDX_W-1:0]   idx_r;
   logic               save_done_r;
   logic [3:0]         prev_num_r;

   mode_e              mode_s;
   logic               mode_chg;
   logic               rec_s;
   logic               idx_ok;
   logic               cap_go;
   logic [IDX_W-1:0]   cap_idx;
   logic               slot_clr;
   logic [NUM_PTS-1:0] slot_we;
   logic [3:0]         sound_num_s;

   // Capture arming decode: a fresh in-range request retargets, and the
   // capture fires on the first visible pixel while armed.
   always_comb begin
      mode_s   = mode_e'(i_mode);
      mode_chg = (mode_s != mode_r);
      rec_s    = (mode_s == MODE_RECORD) && !mode_chg;
      idx_ok   = i_save && (i_save_idx < NUM_PTS_I);
      cap_go   = rec_s && i_pix_valid && (idx_ok || armed_r);
      cap_idx  = idx_ok ? i_save_idx : idx_r;
      slot_clr = (mode_s == MODE_RECORD) || mode_chg;
      for (int i = 0; i < NUM_PTS; i++) begin
         slot_we[i] = cap_go && (cap_idx == IDX_W'(i));
      end
   end

   // Mode tracking, capture arming, done strobe and last reported sound number.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         mode_r      <= MODE_RECORD;
         armed_r     <= 1'b0;
         idx_r       <= '0;
         save_done_r <= 1'b0;
         prev_num_r  <= 4'd0;
      end else begin
         mode_r      <= mode_s;
         save_done_r <= cap_go;
         prev_num_r  <= sound_num_s;
         if (!rec_s || cap_go) begin
            armed_r <= 1'b0;
         end else if (idx_ok) begin
            armed_r <= 1'b1;
            idx_r   <= i_save_idx;
         end
      end
   end

   for (genvar i = 0; i < NUM_PTS; i++) begin : g_slot
      sound_trigger_slot #(
         .COORD_W    (COORD_W),
         .COLOR_W    (COLOR_W),
         .TOL        (TOL),
         .HIT_FRAMES (HIT_FRAMES)
      ) u_slot (
         .clk         (iCLK),
         .rst_n       (iRST_N),
         .clr         (slot_clr),
         .we          (slot_we[i]),
         .pix_valid   (i_pix_valid),
         .frame_start (i_frame_start),
         .x           (i_x),
         .y           (i_y),
         .r           (i_vga_r),
         .g           (i_vga_g),
         .b           (i_vga_b),
         .active      (o_hit_mask[i])
      );
   end

   // Lowest-index priority encoder over the active slots (index + 1, 0 = silent).
   always_comb begin
      sound_num_s = 4'd0;
      for (int i = NUM_PTS - 1; i >= 0; i--) begin
         if (o_hit_mask[i]) begin
            sound_num_s = 4'(i + 1);
         end else begin
            sound_num_s = sound_num_s;
         end
      end
   end

   assign o_save_done   = save_done_r;
   assign o_sound_num   = sound_num_s;
   assign o_sound_valid = (sound_num_s != prev_num_r) && (sound_num_s != 4'd0);

endmodule

// File: tb/tb_sound_trigger_ctrl.sv
// tb_sound_trigger_ctrl: directed scenarios plus randomized traffic for
// sound_trigger_ctrl, checked against a frame-level reference model.
module tb_sound_trigger_ctrl;
   import sound_ctrl_pkg::*;

   localparam int NUM_PTS    = 4;
   localparam int COORD_W    = 10;
   localparam int COLOR_W    = 10;
   localparam int TOL        = 48;
   localparam int HIT_FRAMES = 3;

   logic               iCLK = 1'b0;
   logic               iRST_N;
   logic               i_pix_valid;
   logic               i_frame_start;
   logic [COORD_W-1:0] i_x;
   logic [COORD_W-1:0] i_y;
   logic [COLOR_W-1:0] i_vga_r;
   logic [COLOR_W-1:0] i_vga_g;
   logic [COLOR_W-1:0] i_vga_b;
   logic               i_mode;
   logic               i_save;
   logic [3:0]         i_save_idx;
   logic               o_save_done;
   logic [NUM_PTS-1:0] o_hit_mask;
   logic [3:0]         o_sound_num;
   logic               o_sound_valid;

   sound_trigger_ctrl #(
      .NUM_PTS(NUM_PTS), .COORD_W(COORD_W), .COLOR_W(COLOR_W),
      .TOL(TOL), .HIT_FRAMES(HIT_FRAMES)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .i_pix_valid(i_pix_valid),
      .i_frame_start(i_frame_start), .i_x(i_x), .i_y(i_y),
      .i_vga_r(i_vga_r), .i_vga_g(i_vga_g), .i_vga_b(i_vga_b),
      .i_mode(i_mode), .i_save(i_save), .i_save_idx(i_save_idx),
      .o_save_done(o_save_done), .o_hit_mask(o_hit_mask),
      .o_sound_num(o_sound_num), .o_sound_valid(o_sound_valid)
   );

   always #5 iCLK = ~iCLK;

   // Reference model state
   slot_t              ms[NUM_PTS];
   bit                 mflag[NUM_PTS];
   int                 mcnt[NUM_PTS];
   bit                 marmed;
   int                 midx;
   bit                 mmode;
   bit                 exp_done;
   bit                 exp_valid;
   int                 exp_num;
   logic [NUM_PTS-1:0] exp_mask;

   int n_cmp = 0;
   int n_err = 0;

   function automatic bit ref_hit(input slot_t s, input int r, input int g, input int b);
      int d;
      int t;
      bit h;
`ifdef SOUND_PER_CHANNEL_CMP_EN
      t = TOL % (1 << COLOR_W);
      h = 1'b0;
      d = r - int'(s.r); if (d < 0) d = -d; if (d > t) h = 1'b1;
      d = g - int'(s.g); if (d < 0) d = -d; if (d > t) h = 1'b1;
      d = b - int'(s.b); if (d < 0) d = -d; if (d > t) h = 1'b1;
`else
      t = TOL;
      d = (r + g + b) - (int'(s.r) + int'(s.g) + int'(s.b));
      if (d < 0) d = -d;
      h = (d > t);
`endif
      return h;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      int prev;
      bit h[NUM_PTS];
      prev     = exp_num;
      exp_done = 1'b0;
      if (!iRST_N) begin
         for (int i = 0; i < NUM_PTS; i++) begin
            ms[i] = '0; mflag[i] = 1'b0; mcnt[i] = 0;
         end
         marmed = 1'b0; mmode = 1'b0; prev = 0;
      end else if (i_mode != mmode || i_mode == 1'b0) begin
         for (int i = 0; i < NUM_PTS; i++) begin
            mflag[i] = 1'b0; mcnt[i] = 0;
         end
         if (i_mode != mmode) begin
            marmed = 1'b0;
         end else begin
            if (i_save && int'(i_save_idx) < NUM_PTS) begin
               marmed = 1'b1; midx = int'(i_save_idx);
            end
            if (marmed && i_pix_valid) begin
               ms[midx].x = i_x; ms[midx].y = i_y;
               ms[midx].r = i_vga_r; ms[midx].g = i_vga_g; ms[midx].b = i_vga_b;
               ms[midx].valid = 1'b1;
               marmed = 1'b0; exp_done = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < NUM_PTS; i++) begin
            h[i] = ms[i].valid && i_pix_valid && ms[i].x == i_x && ms[i].y == i_y &&
                   ref_hit(ms[i], int'(i_vga_r), int'(i_vga_g), int'(i_vga_b));
            if (i_frame_start) begin
               if (mflag[i] && ms[i].valid) mcnt[i] = (mcnt[i] < HIT_FRAMES) ? mcnt[i] + 1 : HIT_FRAMES;
               else mcnt[i] = 0;
               mflag[i] = h[i];
            end else begin
               mflag[i] = mflag[i] | h[i];
            end
         end
      end
      mmode   = iRST_N ? i_mode : 1'b0;
      exp_num = 0;
      for (int i = 0; i < NUM_PTS; i++) exp_mask[i] = ms[i].valid && (mcnt[i] == HIT_FRAMES);
      for (int i = 0; i < NUM_PTS; i++) if (exp_mask[i] && exp_num == 0) exp_num = i + 1;
      exp_valid = (exp_num != prev) && (exp_num != 0);
   endtask

   task automatic cycle();
      model_edge();
      @(posedge iCLK);
      #1;
   endtask

   task automatic set_idle();
      i_pix_valid = 1'b0; i_frame_start = 1'b0; i_save = 1'b0;
   endtask

   task automatic drive_pixel(input int x, input int y, input int r, input int g, input int b);
      i_pix_valid = 1'b1;
      i_x = COORD_W'(x); i_y = COORD_W'(y);
      i_vga_r = COLOR_W'(r); i_vga_g = COLOR_W'(g); i_vga_b = COLOR_W'(b);
      cycle();
      set_idle();
   endtask

   task automatic drive_fs();
      i_frame_start = 1'b1;
      cycle();
      set_idle();
   endtask

   task automatic record_slot(input int idx, input int x, input int y, input int c);
      i_save = 1'b1; i_save_idx = 4'(idx);
      drive_pixel(x, y, c, c, c);
   endtask

   task automatic test_reset();
      iRST_N = 1'b0; i_mode = 1'($urandom_range(0, 1));
      i_pix_valid = 1'($urandom_range(0, 1)); i_frame_start = 1'b1;
      i_save = 1'b1; i_save_idx = 4'd1;
      cycle(); cycle();
      n_cmp++; if (o_save_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", o_save_done); end
      n_cmp++; if (o_hit_mask !== 4'b0000) begin n_err++; $display("FAIL reset_mask: got %0b expected 0", o_hit_mask); end
      n_cmp++; if (o_sound_num !== 4'd0) begin n_err++; $display("FAIL reset_num: got %0d expected 0", o_sound_num); end
      n_cmp++; if (o_sound_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", o_sound_valid); end
      iRST_N = 1'b1; i_mode = 1'b0; set_idle();
      cycle();
   endtask

   task automatic test_record();
      i_save = 1'b1; i_save_idx = 4'd2;
      cycle();
      set_idle();
      cycle();
      n_cmp++; if (o_save_done !== 1'b0) begin n_err++; $display("FAIL rec_armed_nopix: got %0b expected 0", o_save_done); end
      drive_pixel(100, 50, 200, 200, 200);
      n_cmp++; if (o_save_done !== 1'b1) begin n_err++; $display("FAIL rec_done: got %0b expected 1", o_save_done); end
      cycle();
      n_cmp++; if (o_save_done !== 1'b0) begin n_err++; $display("FAIL rec_done_single: got %0b expected 0", o_save_done); end
      record_slot(7, 100, 50, 5);
      n_cmp++; if (o_save_done !== 1'b0) begin n_err++; $display("FAIL rec_bad_idx: got %0b expected 0", o_save_done); end
      drive_pixel(100, 50, 5, 5, 5);
      n_cmp++; if (o_save_done !== 1'b0) begin n_err++; $display("FAIL rec_bad_idx_noarm: got %0b expected 0", o_save_done); end
      record_slot(0, 10, 10, 100);
      n_cmp++; if (o_save_done !== 1'b1) begin n_err++; $display("FAIL rec_slot0: got %0b expected 1", o_save_done); end
      record_slot(1, 20, 20, 100);
      record_slot(3, 30, 30, 100);
      n_cmp++; if (o_save_done !== exp_done) begin n_err++; $display("FAIL rec_slot3: got %0b expected %0b", o_save_done, exp_done); end
      cycle();
   endtask

   task automatic test_play_debounce();
      i_mode = 1'b1; cycle();
      for (int f = 0; f < 3; f++) begin
         drive_pixel(100, 50, 10, 10, 10);
         drive_fs();
         n_cmp++; if (o_hit_mask !== exp_mask) begin n_err++; $display("FAIL deb_mask_f%0d: got %0b expected %0b", f, o_hit_mask, exp_mask); end
      end
      n_cmp++; if (o_hit_mask !== 4'b0100) begin n_err++; $display("FAIL deb_mask: got %0b expected 0100", o_hit_mask); end
      n_cmp++; if (o_sound_num !== 4'd3) begin n_err++; $display("FAIL deb_num: got %0d expected 3", o_sound_num); end
      n_cmp++; if (o_sound_valid !== 1'b1) begin n_err++; $display("FAIL deb_valid: got %0b expected 1", o_sound_valid); end
      cycle();
      n_cmp++; if (o_sound_valid !== 1'b0) begin n_err++; $display("FAIL deb_valid_once: got %0b expected 0", o_sound_valid); end
      n_cmp++; if (o_sound_num !== 4'd3) begin n_err++; $display("FAIL deb_num_hold: got %0d expected 3", o_sound_num); end
   endtask

   task automatic test_threshold();
      drive_pixel(100, 50, 152, 200, 200);
      drive_fs();
      n_cmp++; if (o_hit_mask !== 4'b0000) begin n_err++; $display("FAIL thr_48_nohit: got %0b expected 0000", o_hit_mask); end
      for (int f = 0; f < 3; f++) begin
         drive_pixel(100, 50, 151, 200, 200);
         drive_fs();
         if (f == 0) begin
            n_cmp++; if (o_sound_num !== 4'd0) begin n_err++; $display("FAIL thr_49_f0: got %0d expected 0", o_sound_num); end
         end
      end
      n_cmp++; if (o_hit_mask !== 4'b0100) begin n_err++; $display("FAIL thr_49_hit: got %0b expected 0100", o_hit_mask); end
      n_cmp++; if (o_sound_valid !== 1'b1) begin n_err++; $display("FAIL thr_49_valid: got %0b expected 1", o_sound_valid); end
   endtask

   task automatic test_priority();
      for (int f = 0; f < 3; f++) begin
         drive_pixel(20, 20, 0, 0, 0);
         drive_pixel(30, 30, 0, 0, 0);
         drive_fs();
         n_cmp++; if (o_sound_num !== 4'(exp_num)) begin n_err++; $display("FAIL prio_num_f%0d: got %0d expected %0d", f, o_sound_num, exp_num); end
      end
      n_cmp++; if (o_sound_num !== 4'd2) begin n_err++; $display("FAIL prio_num: got %0d expected 2", o_sound_num); end
      n_cmp++; if (o_sound_valid !== 1'b1) begin n_err++; $display("FAIL prio_valid: got %0b expected 1", o_sound_valid); end
      drive_pixel(20, 20, 100, 100, 100);
      drive_pixel(30, 30, 0, 0, 0);
      drive_fs();
      n_cmp++; if (o_sound_num !== 4'd4) begin n_err++; $display("FAIL prio_next_num: got %0d expected 4", o_sound_num); end
      n_cmp++; if (o_sound_valid !== 1'b1) begin n_err++; $display("FAIL prio_next_valid: got %0b expected 1", o_sound_valid); end
      n_cmp++; if (o_hit_mask !== 4'b1000) begin n_err++; $display("FAIL prio_next_mask: got %0b expected 1000", o_hit_mask); end
   endtask

   task automatic test_bounce();
      int pat[4] = '{0, 0, 100, 0};
      for (int f = 0; f < 4; f++) begin
         drive_pixel(10, 10, pat[f], pat[f], pat[f]);
         drive_fs();
         n_cmp++; if (o_sound_num !== 4'd0) begin n_err++; $display("FAIL bounce_num_f%0d: got %0d expected 0", f, o_sound_num); end
         n_cmp++; if (o_hit_mask !== exp_mask) begin n_err++; $display("FAIL bounce_mask_f%0d: got %0b expected %0b", f, o_hit_mask, exp_mask); end
      end
   endtask

   task automatic test_mode_switch();
      for (int f = 0; f < 2; f++) begin
         drive_pixel(10, 10, 0, 0, 0);
         drive_fs();
      end
      n_cmp++; if (o_sound_num !== 4'd1) begin n_err++; $display("FAIL msw_active: got %0d expected 1", o_sound_num); end
      drive_pixel(10, 10, 0, 0, 0);
      i_mode = 1'b0;
      drive_pixel(10, 10, 0, 0, 0);
      n_cmp++; if (o_hit_mask !== 4'b0000) begin n_err++; $display("FAIL msw_mask: got %0b expected 0000", o_hit_mask); end
      n_cmp++; if (o_sound_num !== 4'd0) begin n_err++; $display("FAIL msw_num: got %0d expected 0", o_sound_num); end
      n_cmp++; if (o_sound_valid !== 1'b0) begin n_err++; $display("FAIL msw_valid: got %0b expected 0", o_sound_valid); end
   endtask

   task automatic test_channel();
      logic [3:0] want;
      i_mode = 1'b1; cycle();
      for (int f = 0; f < 3; f++) begin
         drive_pixel(100, 50, 140, 260, 200);
         drive_fs();
      end
`ifdef SOUND_PER_CHANNEL_CMP_EN
      want = 4'b0100;
`else
      want = 4'b0000;
`endif
      n_cmp++; if (o_hit_mask !== want) begin n_err++; $display("FAIL chan_balanced: got %0b expected %0b", o_hit_mask, want); end
      for (int f = 0; f < 3; f++) begin
         drive_pixel(100, 50, 140, 200, 200);
         drive_fs();
      end
      n_cmp++; if (o_hit_mask !== 4'b0100) begin n_err++; $display("FAIL chan_r60: got %0b expected 0100", o_hit_mask); end
      n_cmp++; if (o_sound_num !== 4'd3) begin n_err++; $display("FAIL chan_r60_num: got %0d expected 3", o_sound_num); end
   endtask

   task automatic test_reset_mid();
      i_mode = 1'b0; cycle();
      i_save = 1'b1; i_save_idx = 4'd1; cycle(); set_idle();
      iRST_N = 1'b0; cycle(); iRST_N = 1'b1;
      drive_pixel(20, 20, 50, 50, 50);
      n_cmp++; if (o_save_done !== 1'b0) begin n_err++; $display("FAIL rstmid_disarm: got %0b expected 0", o_save_done); end
      n_cmp++; if (o_save_done !== exp_done) begin n_err++; $display("FAIL rstmid_model: got %0b expected %0b", o_save_done, exp_done); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         iRST_N = ($urandom_range(0, 999) != 0);
         if ($urandom_range(0, 199) == 0) i_mode = ~i_mode;
         i_pix_valid   = ($urandom_range(0, 3) != 0);
         i_frame_start = ($urandom_range(0, 7) == 0);
         i_save        = (i_mode == 1'b0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         i_save_idx    = 4'($urandom_range(0, 5));
         i_x     = COORD_W'($urandom_range(0, 1));
         i_y     = COORD_W'($urandom_range(0, 1));
         i_vga_r = COLOR_W'(100 + 20 * $urandom_range(0, 3));
         i_vga_g = COLOR_W'(100 + 20 * $urandom_range(0, 3));
         i_vga_b = COLOR_W'(100 + 20 * $urandom_range(0, 3));
         cycle();
         n_cmp++; if (o_save_done !== exp_done) begin n_err++; $display("FAIL rnd_done c%0d: got %0b expected %0b", c, o_save_done, exp_done); end
         n_cmp++; if (o_hit_mask !== exp_mask) begin n_err++; $display("FAIL rnd_mask c%0d: got %0b expected %0b", c, o_hit_mask, exp_mask); end
         n_cmp++; if (o_sound_num !== 4'(exp_num)) begin n_err++; $display("FAIL rnd_num c%0d: got %0d expected %0d", c, o_sound_num, exp_num); end
         n_cmp++; if (o_sound_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, o_sound_valid, exp_valid); end
      end
      iRST_N = 1'b1; set_idle(); cycle();
   endtask

   initial begin
      iRST_N = 1'b0; i_mode = 1'b0; set_idle(); i_save_idx = 4'd0;
      i_x = '0; i_y = '0; i_vga_r = '0; i_vga_g = '0; i_vga_b = '0;
      exp_num = 0; exp_mask = '0; exp_done = 1'b0; exp_valid = 1'b0;
      marmed = 1'b0; midx = 0; mmode = 1'b0;
      test_reset();
      test_record();
      test_play_debounce();
      test_threshold();
      test_priority();
      test_bounce();
      test_mode_switch();
      test_channel();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
